// File: rtl/axi_ram_rd_slave.sv
// AXI4 read-only slave over an internal synchronous RAM with a byte-masked backdoor write port.
// Serves FIXED/INCR/WRAP bursts of 1-256 beats; malformed requests answer SLVERR beats with zero data.
module axi_ram_rd_slave #(
    parameter int DATA_WIDTH     = 64,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 8,
    parameter int RUSER_WIDTH    = 1,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      m_clk,
    input  logic                      s_rst,

    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]    s_axi_ruser,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    input  logic                      mem_wr_en,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wr_data,
    input  logic [STRB_WIDTH-1:0]     mem_wr_strb
);

    localparam int             LG_STRB  = $clog2(STRB_WIDTH);
    localparam logic [2:0]     MAX_SIZE = 3'(LG_STRB);
    localparam logic [1:0]     BURST_FIXED = 2'b00;
    localparam logic [1:0]     BURST_INCR  = 2'b01;
    localparam logic [1:0]     BURST_WRAP  = 2'b10;
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [2**MEM_ADDR_WIDTH];

    logic [ID_WIDTH-1:0]       id_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      err_q;
    logic [8:0]                beat;

    logic                      ar_err;
    logic [ADDR_WIDTH-1:0]     ar_size_mask;
    logic [ADDR_WIDTH-1:0]     step;
    logic [ADDR_WIDTH-1:0]     wrap_mask;
    logic [ADDR_WIDTH-1:0]     addr_nxt;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic                      load;

    assign s_axi_ruser = '0;

    // Request validation on the incoming AR payload, captured with the handshake.
    always_comb begin
        ar_err       = 1'b0;
        ar_size_mask = (ADDR_WIDTH'(1) << s_axi_arsize) - ADDR_WIDTH'(1);
        if (s_axi_arsize > MAX_SIZE) begin
            ar_err = 1'b1;
        end
        if (s_axi_arburst == 2'b11) begin
            ar_err = 1'b1;
        end
        if (s_axi_arburst == BURST_WRAP) begin
            if (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                ar_err = 1'b1;
            end
            if ((s_axi_araddr & ar_size_mask) != '0) begin
                ar_err = 1'b1;
            end
        end
    end

    // Next beat address; the INCR form also realigns an unaligned first beat.
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            BURST_INCR: addr_nxt = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
            BURST_WRAP: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default:    addr_nxt = addr_q;
        endcase
    end

    assign word_idx = addr_q[MEM_ADDR_WIDTH+LG_STRB-1:LG_STRB];
    assign load     = (state == READ) && (!s_axi_rvalid || s_axi_rready)
                      && (beat <= {1'b0, len_q});

    // NOTE: the RAM has no reset so it maps onto block RAM; its contents survive s_rst.
    always_ff @(posedge m_clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (mem_wr_strb[b]) begin
                    mem[mem_wr_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking updates make a same-edge backdoor write invisible to the read (read-first).
    always_ff @(posedge m_clk) begin
        if (s_rst) begin
            state         <= IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            beat          <= '0;
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= BURST_FIXED;
            err_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        id_q          <= s_axi_arid;
                        addr_q        <= s_axi_araddr;
                        len_q         <= s_axi_arlen;
                        size_q        <= s_axi_arsize;
                        burst_q       <= s_axi_arburst;
                        err_q         <= ar_err;
                        beat          <= '0;
                        s_axi_arready <= 1'b0;
                        state         <= READ;
                    end
                end
                READ: begin
                    if (load) begin
                        s_axi_rdata  <= err_q ? '0 : mem[word_idx];
                        s_axi_rresp  <= err_q ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast  <= (beat == {1'b0, len_q});
                        s_axi_rid    <= id_q;
                        s_axi_rvalid <= 1'b1;
                        addr_q       <= addr_nxt;
                        beat         <= beat + 9'd1;
                    end else if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rlast   <= 1'b0;
                        s_axi_arready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_rd_slave.sv
// Self-checking bench for axi_ram_rd_slave: directed bursts from the test plan plus randomized
// traffic, scored against a byte-address model of the AXI burst rules and a word-array RAM model.
module tb_axi_ram_rd_slave;

    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int MAW = 10;
    localparam int DEPTH = 1024;

    logic           m_clk = 1'b0;
    logic           s_rst;
    logic [IW-1:0]  s_axi_arid;
    logic [AW-1:0]  s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic [2:0]     s_axi_arsize;
    logic [1:0]     s_axi_arburst;
    logic           s_axi_arvalid;
    logic           s_axi_arready;
    logic [IW-1:0]  s_axi_rid;
    logic [DW-1:0]  s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic [0:0]     s_axi_ruser;
    logic           s_axi_rvalid;
    logic           s_axi_rready;
    logic           mem_wr_en;
    logic [MAW-1:0] mem_wr_addr;
    logic [DW-1:0]  mem_wr_data;
    logic [SW-1:0]  mem_wr_strb;

    axi_ram_rd_slave #(
        .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ADDR_WIDTH(AW),
        .ID_WIDTH(IW), .RUSER_WIDTH(1), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .m_clk(m_clk), .s_rst(s_rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb)
    );

    always #5 m_clk = ~m_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic [DW-1:0] mem_model [DEPTH];
    beat_t         exp_q [$];
    int            checks = 0;
    int            errors = 0;

    // Expected beats from the AXI burst rules, using plain byte-address arithmetic.
    task automatic build_expected(input logic [IW-1:0] id, input longint unsigned addr,
                                  input int len, input int size, input int burst);
        longint unsigned a, nbytes, bnd, base;
        bit              err;
        beat_t           b;
        int              word;
        a      = addr;
        nbytes = 64'd1 << size;
        err    = (size > 3) || (burst == 3)
                 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
                 || (burst == 2 && (a % nbytes) != 0);
        exp_q.delete();
        for (int i = 0; i <= len; i++) begin
            word   = int'((a / SW) % DEPTH);
            b.data = err ? '0 : mem_model[word];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            b.id   = id;
            exp_q.push_back(b);
            if (burst == 1) begin
                a = ((a / nbytes) * nbytes + nbytes) % 64'h1_0000_0000;
            end else if (burst == 2) begin
                bnd  = (len + 1) * nbytes;
                base = a - (a % bnd);
                a    = base + ((a + nbytes) % bnd);
            end
        end
    endtask

    task automatic backdoor_write(input int word, input logic [DW-1:0] data, input logic [SW-1:0] strb);
        mem_wr_en   = 1'b1;
        mem_wr_addr = MAW'(word);
        mem_wr_data = data;
        mem_wr_strb = strb;
        @(negedge m_clk);
        mem_wr_en = 1'b0;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) mem_model[word][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    // Presents AR from the current negedge; returns at the negedge right after the handshake edge.
    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst, output int waited);
        waited        = 0;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = 3'(size);
        s_axi_arburst = 2'(burst);
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && waited < 100) begin
            @(negedge m_clk);
            waited++;
        end
        checks++;
        if (!s_axi_arready) begin
            errors++;
            $display("FAIL ar_handshake_timeout: arready=%b required 1", s_axi_arready);
        end
        @(negedge m_clk);
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL ar_accept_state: rvalid=%b arready=%b required 0 0", s_axi_rvalid, s_axi_arready);
        end
    endtask

    // Drains exp_q. mode 0: rready held high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic collect(input int mode, input string tag);
        int    got, cyc, last_cyc, n;
        bit    stalled;
        beat_t prev, act;
        got = 0; cyc = 0; last_cyc = -1; stalled = 0; prev = '0;
        n = exp_q.size();
        while (got < n && cyc < 3000) begin
            @(negedge m_clk);
            mem_wr_en = 1'b0;
            act = '{data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast, id: s_axi_rid};
            if (cyc == 0) begin
                checks++;
                if (s_axi_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s first_beat_latency: rvalid=%b required 1", tag, s_axi_rvalid);
                end
            end
            if (stalled) begin
                checks++;
                if (s_axi_rvalid !== 1'b1 || act !== prev) begin
                    errors++;
                    $display("FAIL %s stall_hold: rvalid=%b beat=%h required 1 %h", tag, s_axi_rvalid, act, prev);
                end
            end
            checks++;
            if (s_axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL %s arready_busy: arready=%b required 0", tag, s_axi_arready);
            end
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = (cyc % 3 == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            stalled = 1'b0;
            if (s_axi_rvalid) begin
                if (s_axi_rready) begin
                    checks++;
                    if (act !== exp_q[got] || s_axi_ruser !== 1'b0) begin
                        errors++;
                        $display("FAIL %s beat%0d: got data=%h resp=%b last=%b id=%h ruser=%b required data=%h resp=%b last=%b id=%h ruser=0",
                                 tag, got, act.data, act.resp, act.last, act.id, s_axi_ruser,
                                 exp_q[got].data, exp_q[got].resp, exp_q[got].last, exp_q[got].id);
                    end
                    got++;
                    last_cyc = cyc;
                end else begin
                    stalled = 1'b1;
                    prev    = act;
                end
            end
            cyc++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s beat_count_timeout: got %0d beats required %0d", tag, got, n);
        end
        @(negedge m_clk);
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL %s burst_end: rvalid=%b arready=%b required 0 1", tag, s_axi_rvalid, s_axi_arready);
        end
        if (mode == 0) begin
            checks++;
            if (last_cyc != n - 1) begin
                errors++;
                $display("FAIL %s throughput: last beat at cycle %0d required %0d", tag, last_cyc, n - 1);
            end
        end
    endtask

    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input int size, input int burst, input int mode, input string tag);
        int waited;
        build_expected(id, addr, len, size, burst);
        send_ar(id, addr, len, size, burst, waited);
        collect(mode, tag);
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        repeat (3) @(negedge m_clk);
        checks++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 ||
            s_axi_rresp !== 2'b00 || s_axi_rid !== '0 || s_axi_rdata !== '0 || s_axi_ruser !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: arready=%b rvalid=%b rlast=%b rresp=%b rid=%h rdata=%h required 1 0 0 00 00 0",
                     s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rid, s_axi_rdata);
        end
        s_rst = 1'b0;
        @(negedge m_clk);
    endtask

    task automatic test_preload();
        for (int k = 0; k < DEPTH; k++) begin
            backdoor_write(k, 64'h1000_0000_0000_0000 + 64'(k), 8'hFF);
        end
    endtask

    task automatic test_basic_bursts();
        run_burst(8'h5A, 32'h40, 3, 3, 1, 0, "incr_aligned");
        run_burst(8'h11, 32'h38, 3, 3, 2, 0, "wrap_len3");
        run_burst(8'h22, 32'h10, 2, 3, 0, 0, "fixed");
        run_burst(8'h33, 32'h0D, 1, 3, 1, 0, "incr_unaligned");
        run_burst(8'h44, 32'h04, 3, 2, 1, 0, "narrow_size2");
        run_burst(8'h55, 32'h1F8, 255, 3, 1, 0, "incr_256beats");
        run_burst(8'h66, 32'hFFFF_FFF8, 2, 3, 1, 0, "incr_addr_wrap");
        run_burst(8'h77, 32'h78, 15, 3, 2, 0, "wrap_len15");
    endtask

    task automatic test_backpressure();
        run_burst(8'h99, 32'h80, 7, 3, 1, 1, "backpressure");
    endtask

    task automatic test_errors();
        run_burst(8'hE0, 32'h40, 2, 4, 1, 0, "err_size4");
        run_burst(8'hE1, 32'h40, 2, 3, 2, 0, "err_wrap_len2");
        run_burst(8'hE2, 32'h40, 1, 3, 3, 0, "err_burst11");
        run_burst(8'hE3, 32'h3C, 3, 3, 2, 1, "err_wrap_unaligned");
        run_burst(8'hE4, 32'h100, 1, 3, 1, 0, "after_errors");
    endtask

    task automatic test_back_to_back();
        int waited;
        build_expected(8'hB0, 32'h200, 2, 3, 1);
        send_ar(8'hB0, 32'h200, 2, 3, 1, waited);
        collect(0, "b2b_first");
        build_expected(8'hB1, 32'h300, 0, 3, 0);
        send_ar(8'hB1, 32'h300, 0, 3, 0, waited);
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL b2b_spacing: waited %0d cycles for arready required 0", waited);
        end
        collect(0, "b2b_second");
    endtask

    task automatic test_reset_mid_burst();
        int    waited;
        beat_t act;
        build_expected(8'hC7, 32'h180, 7, 3, 1);
        send_ar(8'hC7, 32'h180, 7, 3, 1, waited);
        for (int i = 0; i < 2; i++) begin
            @(negedge m_clk);
            s_axi_rready = 1'b1;
            act = '{data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast, id: s_axi_rid};
            checks++;
            if (s_axi_rvalid !== 1'b1 || act !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: rvalid=%b beat=%h required 1 %h", i, s_axi_rvalid, act, exp_q[i]);
            end
        end
        @(negedge m_clk);
        s_axi_rready = 1'b0;
        s_rst        = 1'b1;
        @(negedge m_clk);
        s_rst = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: rvalid=%b arready=%b rlast=%b required 0 1 0",
                     s_axi_rvalid, s_axi_arready, s_axi_rlast);
        end
        s_axi_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge m_clk);
            checks++;
            if (s_axi_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_no_leftover: rvalid=%b required 0", s_axi_rvalid);
            end
        end
        s_axi_rready = 1'b0;
        run_burst(8'hC8, 32'h1C0, 3, 3, 1, 0, "after_reset");
    endtask

    task automatic test_read_first();
        int            waited;
        logic [DW-1:0] new_data;
        new_data = 64'hDEAD_BEEF_CAFE_0014;
        build_expected(8'hD0, 32'hA0, 0, 3, 0);
        send_ar(8'hD0, 32'hA0, 0, 3, 0, waited);
        mem_wr_en   = 1'b1;
        mem_wr_addr = MAW'(20);
        mem_wr_data = new_data;
        mem_wr_strb = 8'hFF;
        collect(0, "collision_old");
        mem_model[20] = new_data;
        run_burst(8'hD1, 32'hA0, 0, 3, 0, 0, "collision_new");
        backdoor_write(21, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        run_burst(8'hD2, 32'hA8, 0, 3, 1, 0, "strobe_write");
    endtask

    task automatic test_random();
        int       len, size, burst, nbytes;
        logic [AW-1:0] addr;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                backdoor_write(int'($urandom_range(0, DEPTH - 1)),
                               {$urandom, $urandom}, 8'($urandom));
            end
            burst = int'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            size  = int'($urandom_range(0, 9) == 0 ? $urandom_range(4, 7) : $urandom_range(0, 3));
            if (burst == 2 && $urandom_range(0, 4) != 0) begin
                len = (2 << $urandom_range(0, 3)) - 1;
            end else begin
                len = int'($urandom_range(0, 20));
            end
            nbytes = 1 << size;
            addr   = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~AW'(nbytes - 1);
            run_burst(8'($urandom), addr, len, size, burst, 2, "random");
        end
    endtask

    initial begin
        s_rst         = 1'b1;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_data   = '0;
        mem_wr_strb   = '0;
        @(negedge m_clk);
        test_reset();
        test_preload();
        test_basic_bursts();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_reset_mid_burst();
        test_read_first();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
